// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared MIPS pipeline constants: control-word bit map and register zero
package mips_pipe_pkg;

   localparam int CTRL_W = 8;

   localparam int CTRL_MEM_READ  = 0;
   localparam int CTRL_MEM_WRITE = 1;
   localparam int CTRL_REG_WRITE = 2;
   localparam int CTRL_ALU_SRC   = 3;
   localparam int CTRL_ALUOP_LSB = 4;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_hazard.sv
// rtl/id_ex_hazard.sv - combinational load-use hazard and ID stall detection
module id_ex_hazard
   import mips_pipe_pkg::*;
(
   input  logic       ex_valid,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rt,
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       flush,
   input  logic       hold,
   output logic       load_use,
   output logic       id_stall
);

   // A load into r0 never produces a usable value, so it cannot create a hazard.
   assign load_use = ex_valid && ex_mem_read && (ex_rt != REG_ZERO) && id_valid &&
                     ((ex_rt == id_rs) || (ex_rt == id_rt));

   assign id_stall = (load_use || hold) && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with WB bypass, load-use bubble, flush and hold
// Optional performance counters enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage #(
   parameter int CTRL_W = mips_pipe_pkg::CTRL_W,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic [31:0]       id_rs_data,
   input  logic [31:0]       id_rt_data,
   input  logic [31:0]       id_imm,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              wb_reg_write,
   input  logic [4:0]        wb_rd,
   input  logic [31:0]       wb_data,
   input  logic              flush,
   input  logic              hold,
   output logic              id_stall,
   output logic              ex_valid,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_rd,
   output logic [31:0]       ex_rs_data,
   output logic [31:0]       ex_rt_data,
   output logic [31:0]       ex_imm,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);
   import mips_pipe_pkg::*;

   logic        load_use;
   logic [31:0] rs_opnd;
   logic [31:0] rt_opnd;

   id_ex_hazard u_hazard (
      .ex_valid    (ex_valid),
      .ex_mem_read (ex_ctrl[CTRL_MEM_READ]),
      .ex_rt       (ex_rt),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .flush       (flush),
      .hold        (hold),
      .load_use    (load_use),
      .id_stall    (id_stall)
   );

   // r0 reads as zero; otherwise a same-cycle WB write to the source wins over the stale RF read.
   always_comb begin
      rs_opnd = id_rs_data;
      rt_opnd = id_rt_data;
      if (id_rs == REG_ZERO)
         rs_opnd = '0;
      else if (wb_reg_write && (wb_rd == id_rs))
         rs_opnd = wb_data;
      if (id_rt == REG_ZERO)
         rt_opnd = '0;
      else if (wb_reg_write && (wb_rd == id_rt))
         rt_opnd = wb_data;
   end

   // Hold outranks the load-use bubble; flush outranks both.
   always_ff @(posedge clk) begin
      if (reset || flush || (load_use && !hold)) begin
         ex_valid   <= 1'b0;
         ex_rs      <= '0;
         ex_rt      <= '0;
         ex_rd      <= '0;
         ex_rs_data <= '0;
         ex_rt_data <= '0;
         ex_imm     <= '0;
         ex_ctrl    <= '0;
      end else if (!hold) begin
         ex_valid   <= id_valid;
         ex_rs      <= id_rs;
         ex_rt      <= id_rt;
         ex_rd      <= id_rd;
         ex_rs_data <= rs_opnd;
         ex_rt_data <= rt_opnd;
         ex_imm     <= id_imm;
         ex_ctrl    <= id_valid ? id_ctrl : '0;
      end
   end

`ifdef ID_EX_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (load_use && !flush && !hold && (stall_q != '1))
            stall_q <= stall_q + CNT_W'(1);
         if (flush && (flush_q != '1))
            flush_q <= flush_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
